// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: byte/half/word writes, word reads, WAIT_STATES wait cycles per OKAY transfer.
// Illegal size, misaligned or out-of-range accesses get the two-cycle ERROR response and never touch memory.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hselx,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hmastlock,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t             state, state_n;
    logic [3:0]         count;
    logic               pend;
    logic               pend_write;
    logic [IDX_W-1:0]   pend_idx;
    logic [3:0]         pend_be;
    logic               accept;
    logic               err;
    logic               size_bad;
    logic               misalign;
    logic               range_bad;
    logic [3:0]         be;
    logic               open_slot;
    logic               wr_en;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic unused;
    assign unused = ^{hburst, hprot, hmastlock, htrans[0]};

    // New address phases are only taken when no data phase of ours is stalling the bus.
    assign open_slot = (state == IDLE) || (state == ERR2);
    assign accept    = open_slot && hselx && hready && htrans[1];

    assign size_bad  = hsize > 3'd2;
    assign misalign  = ((hsize == 3'd1) && haddr[0]) ||
                       ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    // Full-width compare so high address bits never alias into the array.
    assign range_bad = haddr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH);
    assign err       = size_bad || misalign || range_bad;

    always_comb begin
        be = 4'b0000;
        case (hsize)
            3'd0:    be = 4'b0001 << haddr[1:0];
            3'd1:    be = haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= IDLE;
            count      <= 4'd0;
            pend       <= 1'b0;
            pend_write <= 1'b0;
            pend_idx   <= '0;
            pend_be    <= 4'b0000;
        end else begin
            state <= state_n;
            if (open_slot && hready) begin
                pend <= accept && !err;
            end
            if (accept) begin
                pend_write <= hwrite;
                pend_idx   <= haddr[IDX_W+1:2];
                pend_be    <= be;
            end
            if (accept && !err) begin
                count <= 4'(WAIT_STATES);
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        hreadyout = 1'b1;
        hresp     = 2'b00;
        case (state)
            IDLE, ERR2: begin
                if (state == ERR2) begin
                    hresp = 2'b01;
                end
                if (hready) begin
                    if (accept) begin
                        state_n = err ? ERR1 : ((WAIT_STATES > 0) ? WAIT : IDLE);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            WAIT: begin
                hreadyout = 1'b0;
                if (count == 4'd1) begin
                    state_n = IDLE;
                end
            end
            ERR1: begin
                hreadyout = 1'b0;
                hresp     = 2'b01;
                state_n   = ERR2;
            end
            default: state_n = IDLE;
        endcase
    end

    // The completing data phase is IDLE with a pending OKAY transfer and the bus ready.
    assign wr_en = (state == IDLE) && pend && pend_write && hready;

    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (pend_be[i]) begin
                    mem[pend_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign hrdata = ((state == IDLE) && pend && !pend_write) ? mem[pend_idx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: dut0 runs with zero wait states, dut1 with three; they share the address/data bus.
module tb_ahb_sram_slave;

    localparam logic [1:0] IDL  = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NS   = 2'b10;

    logic        hclk;
    logic        hresetn;
    logic        sel0, sel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hold;
    logic        hready0, hready1;
    logic        hreadyout0, hreadyout1;
    logic [1:0]  hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1;

    int checks = 0;
    int errors = 0;

    assign hready0 = hreadyout0 & ~hold;
    assign hready1 = hreadyout1 & ~hold;

    ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hselx(sel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
        .hwdata(hwdata), .hready(hready0), .hreadyout(hreadyout0), .hresp(hresp0),
        .hrdata(hrdata0)
    );

    ahb_sram_slave #(.WAIT_STATES(3)) dut1 (
        .hclk(hclk), .hresetn(hresetn), .hselx(sel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
        .hwdata(hwdata), .hready(hready1), .hreadyout(hreadyout1), .hresp(hresp1),
        .hrdata(hrdata1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle's inputs, then step to just after the closing edge.
    task automatic cyc(input logic s0, input logic s1, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        sel0   = s0;
        sel1   = s1;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hwdata = wd;
        @(posedge hclk);
        #1;
    endtask

    task automatic idle(input logic [31:0] wd);
        cyc(1'b0, 1'b0, IDL, 1'b0, 3'd0, 32'h0, wd);
    endtask

    initial begin
        hresetn = 1'b0;
        hold    = 1'b0;
        sel0 = 1'b0; sel1 = 1'b0; haddr = '0; htrans = IDL; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_rdy0",  32'(hreadyout0), 32'd1);
        chk("rst_resp0", 32'(hresp0),     32'd0);
        chk("rst_rdat0", hrdata0,         32'd0);
        chk("rst_rdy1",  32'(hreadyout1), 32'd1);
        hresetn = 1'b1;

        // Zero-wait word write/read, back-to-back.
        cyc(1, 0, NS, 1, 3'd2, 32'h00, 32'h0);
        cyc(1, 0, NS, 1, 3'd2, 32'h10, 32'h0BADF00D);
        chk("w_rdy", 32'(hreadyout0), 32'd1);
        cyc(1, 0, NS, 0, 3'd2, 32'h10, 32'hDEADBEEF);
        chk("rd10_rdy",  32'(hreadyout0), 32'd1);
        chk("rd10_resp", 32'(hresp0),     32'd0);
        chk("rd10_dat",  hrdata0,         32'hDEADBEEF);
        idle(32'h0);
        chk("rd_idle_dat", hrdata0, 32'd0);

        // Byte lanes then halfword overwrite; unused lanes carry junk.
        cyc(1, 0, NS, 1, 3'd0, 32'h20, 32'h0);
        cyc(1, 0, NS, 1, 3'd0, 32'h21, 32'hA5A5A511);
        cyc(1, 0, NS, 1, 3'd0, 32'h22, 32'hA5A522A5);
        cyc(1, 0, NS, 1, 3'd0, 32'h23, 32'hA533A5A5);
        cyc(1, 0, NS, 1, 3'd1, 32'h22, 32'h44A5A5A5);
        cyc(1, 0, NS, 0, 3'd2, 32'h20, 32'hAAAA5A5A);
        chk("lanes_dat", hrdata0, 32'hAAAA2211);
        idle(32'h0);

        // Misaligned word write to 0x12, then NONSEQ read accepted in ERR2.
        cyc(1, 0, NS, 1, 3'd2, 32'h12, 32'h0);
        chk("mis_e1_rdy",  32'(hreadyout0), 32'd0);
        chk("mis_e1_resp", 32'(hresp0),     32'd1);
        chk("mis_e1_dat",  hrdata0,         32'd0);
        idle(32'h12345678);
        chk("mis_e2_rdy",  32'(hreadyout0), 32'd1);
        chk("mis_e2_resp", 32'(hresp0),     32'd1);
        cyc(1, 0, NS, 0, 3'd2, 32'h10, 32'h12345678);
        chk("mis_nx_resp", 32'(hresp0), 32'd0);
        chk("mis_nx_dat",  hrdata0,     32'hDEADBEEF);
        idle(32'h0);

        // Out of range word 0x400 must not alias onto word 0.
        cyc(1, 0, NS, 1, 3'd2, 32'h400, 32'h0);
        chk("oor_e1_rdy",  32'(hreadyout0), 32'd0);
        chk("oor_e1_resp", 32'(hresp0),     32'd1);
        idle(32'hFFFFFFFF);
        chk("oor_e2_resp", 32'(hresp0), 32'd1);
        cyc(1, 0, NS, 0, 3'd2, 32'h00, 32'hFFFFFFFF);
        chk("oor_nx_dat", hrdata0, 32'h0BADF00D);
        idle(32'h0);

        // Misaligned + out-of-range read, then ERR2 falls back to IDLE.
        cyc(1, 0, NS, 0, 3'd2, 32'h402, 32'h0);
        chk("e402_e1_rdy", 32'(hreadyout0), 32'd0);
        chk("e402_e1_dat", hrdata0,         32'd0);
        idle(32'h0);
        chk("e402_e2_rdy",  32'(hreadyout0), 32'd1);
        chk("e402_e2_resp", 32'(hresp0),     32'd1);
        idle(32'h0);
        chk("e402_idle_resp", 32'(hresp0), 32'd0);

        // Illegal size 3 write.
        cyc(1, 0, NS, 1, 3'd3, 32'h20, 32'h0);
        chk("sz3_e1_resp", 32'(hresp0), 32'd1);
        chk("sz3_e1_rdy",  32'(hreadyout0), 32'd0);
        idle(32'h0F0F0F0F);
        chk("sz3_e2_resp", 32'(hresp0), 32'd1);
        cyc(1, 0, NS, 0, 3'd2, 32'h20, 32'h0F0F0F0F);
        chk("sz3_nx_dat", hrdata0, 32'hAAAA2211);
        idle(32'h0);

        // hready low, BUSY and deselected NONSEQ must not be accepted.
        cyc(1, 0, NS, 1, 3'd2, 32'h40, 32'h0);
        idle(32'h01010101);
        hold = 1'b1;
        cyc(1, 0, NS, 1, 3'd2, 32'h40, 32'h0);
        hold = 1'b0;
        chk("hold_rdy",  32'(hreadyout0), 32'd1);
        chk("hold_resp", 32'(hresp0),     32'd0);
        idle(32'h77777777);
        cyc(1, 0, BUSY, 1, 3'd2, 32'h40, 32'h0);
        cyc(0, 0, NS,   1, 3'd2, 32'h40, 32'h66666666);
        chk("desel_rdy", 32'(hreadyout0), 32'd1);
        idle(32'h55555555);
        chk("desel_resp", 32'(hresp0), 32'd0);
        cyc(1, 0, NS, 0, 3'd2, 32'h40, 32'h55555555);
        chk("nochg_dat", hrdata0, 32'h01010101);
        idle(32'h0);

        // Three wait states: write with hwdata toggled during waits.
        cyc(0, 1, NS, 1, 3'd2, 32'h50, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("ws_w_wait%0d", i), 32'(hreadyout1), 32'd0);
            idle(32'h11111111 * i);
        end
        chk("ws_w_done_rdy",  32'(hreadyout1), 32'd1);
        chk("ws_w_done_resp", 32'(hresp1),     32'd0);
        idle(32'hCAFEF00D);
        chk("ws_w_after_rdy", 32'(hreadyout1), 32'd1);
        cyc(0, 1, NS, 0, 3'd2, 32'h50, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("ws_r_wait%0d", i), 32'(hreadyout1), 32'd0);
            chk($sformatf("ws_r_dat%0d", i),  hrdata1,         32'd0);
            idle(32'hFFFFFFFF);
        end
        chk("ws_r_rdy",  32'(hreadyout1), 32'd1);
        chk("ws_r_resp", 32'(hresp1),     32'd0);
        chk("ws_r_dat",  hrdata1,         32'hCAFEF00D);
        idle(32'h0);

        // Reset during the wait of a write: immediate return to reset outputs, write dropped.
        cyc(0, 1, NS, 1, 3'd2, 32'h50, 32'h0);
        chk("rw_wait_rdy", 32'(hreadyout1), 32'd0);
        #2;
        hresetn = 1'b0;
        sel1 = 1'b0; htrans = IDL; hwdata = 32'h11112222;
        #1;
        chk("rw_async_rdy",  32'(hreadyout1), 32'd1);
        chk("rw_async_resp", 32'(hresp1),     32'd0);
        chk("rw_async_dat",  hrdata1,         32'd0);
        repeat (2) @(posedge hclk);
        #1;
        hresetn = 1'b1;
        cyc(0, 1, NS, 0, 3'd2, 32'h50, 32'h11112222);
        idle(32'h11112222);
        idle(32'h11112222);
        idle(32'h11112222);
        chk("rw_keep_rdy", 32'(hreadyout1), 32'd1);
        chk("rw_keep_dat", hrdata1,         32'hCAFEF00D);
        idle(32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
